// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module : pc_gen
// Fetch-PC generator: sequential fetch over valid/ready, EX redirects (jal >
// jalr > branch), misaligned-target detection. Optional macro PC_GEN_TRAP_EN
// turns a misaligned redirect into a trap redirect instead of a halt.
// Rev    : 1.0  initial release
// ============================================================================
module pc_gen #(
  parameter int              PC_W       = 16,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter int              INST_BYTES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            jal_en_i,
  input  logic            jalr_en_i,
  input  logic            branch_en_i,
  input  logic [PC_W-1:0] ex_pc_i,
  input  logic [PC_W-1:0] imm_data_i,
  input  logic [PC_W-1:0] alu_data_i,
  output logic            fetch_valid_o,
  input  logic            fetch_ready_i,
  output logic [PC_W-1:0] fetch_pc_o,
  output logic            flush_o,
  output logic            misalign_o,
`ifdef PC_GEN_TRAP_EN
  input  logic [PC_W-1:0] trap_vec_i,
  output logic [PC_W-1:0] epc_o,
`endif
  output logic [PC_W-1:0] misalign_addr_o
);

  localparam int              c_align_w = (INST_BYTES == 4) ? 2 : 1;
  localparam logic [PC_W-1:0] c_inc     = PC_W'(INST_BYTES);
  localparam logic [PC_W-1:0] c_lsb_clr = {{(PC_W-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            flush_q, flush_d;
  logic            misalign_q, misalign_d;
  logic [PC_W-1:0] misalign_addr_q, misalign_addr_d;
`ifdef PC_GEN_TRAP_EN
  logic [PC_W-1:0] epc_q, epc_d;
`endif

  logic            w_redirect;
  logic            w_misaligned;
  logic            w_fire;
  logic [PC_W-1:0] w_target;

  // jal and branch share the PC-relative adder; jalr only wins when jal is absent.
  assign w_redirect   = jal_en_i | jalr_en_i | branch_en_i;
  assign w_target     = (jalr_en_i & ~jal_en_i) ? (alu_data_i & c_lsb_clr)
                                                : (ex_pc_i + imm_data_i);
  assign w_misaligned = |w_target[c_align_w-1:0];
  assign w_fire       = fetch_valid_o & fetch_ready_i;

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    flush_d         = 1'b0;
    misalign_addr_d = misalign_addr_q;
`ifdef PC_GEN_TRAP_EN
    misalign_d      = 1'b0;
    epc_d           = epc_q;
`else
    misalign_d      = misalign_q;
`endif
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (w_redirect) begin
          flush_d = 1'b1;
          if (w_misaligned) begin
            misalign_d      = 1'b1;
            misalign_addr_d = w_target;
`ifdef PC_GEN_TRAP_EN
            epc_d           = ex_pc_i;
            pc_d            = trap_vec_i & c_lsb_clr;
`else
            state_d         = FAULT;
`endif
          end else begin
            pc_d = w_target;
          end
        end else if (w_fire) begin
          pc_d = pc_q + c_inc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= BOOT;
      pc_q            <= RESET_PC;
      flush_q         <= 1'b0;
      misalign_q      <= 1'b0;
      misalign_addr_q <= '0;
`ifdef PC_GEN_TRAP_EN
      epc_q           <= '0;
`endif
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      flush_q         <= flush_d;
      misalign_q      <= misalign_d;
      misalign_addr_q <= misalign_addr_d;
`ifdef PC_GEN_TRAP_EN
      epc_q           <= epc_d;
`endif
    end
  end

  assign fetch_valid_o   = (state_q == RUN) & ~stall_i;
  assign fetch_pc_o      = pc_q;
  assign flush_o         = flush_q;
  assign misalign_o      = misalign_q;
  assign misalign_addr_o = misalign_addr_q;
`ifdef PC_GEN_TRAP_EN
  assign epc_o           = epc_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
// Module : tb_pc_gen
// Directed and random stimulus for pc_gen (default build) against a reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_pc_gen;

  localparam int INST_BYTES = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0, jal_en_i = 1'b0, jalr_en_i = 1'b0, branch_en_i = 1'b0;
  logic        fetch_ready_i = 1'b0;
  logic [15:0] ex_pc_i = '0, imm_data_i = '0, alu_data_i = '0;
  logic        fetch_valid_o, flush_o, misalign_o;
  logic [15:0] fetch_pc_o, misalign_addr_o;

  pc_gen #(.PC_W(16), .RESET_PC(16'h0000), .INST_BYTES(INST_BYTES)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i),
    .jal_en_i(jal_en_i), .jalr_en_i(jalr_en_i), .branch_en_i(branch_en_i),
    .ex_pc_i(ex_pc_i), .imm_data_i(imm_data_i), .alu_data_i(alu_data_i),
    .fetch_valid_o(fetch_valid_o), .fetch_ready_i(fetch_ready_i),
    .fetch_pc_o(fetch_pc_o), .flush_o(flush_o), .misalign_o(misalign_o),
    .misalign_addr_o(misalign_addr_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: 0 = booting, 1 = running, 2 = halted on a bad target
  int          m_mode;
  logic [15:0] m_pc, m_addr;
  logic        m_flush, m_mis;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pc = 16'h0000; m_addr = 16'h0000; m_flush = 1'b0; m_mis = 1'b0;
  endtask

  // Drive one cycle's inputs, compare outputs mid-cycle, then step the model across the edge.
  task automatic cycle(input logic r, input logic s, input logic rdy,
                       input logic j, input logic jr, input logic b,
                       input logic [15:0] ex, input logic [15:0] imm, input logic [15:0] alu);
    logic [15:0] tgt;
    rst = r; stall_i = s; fetch_ready_i = rdy;
    jal_en_i = j; jalr_en_i = jr; branch_en_i = b;
    ex_pc_i = ex; imm_data_i = imm; alu_data_i = alu;
    #4;
    check("valid",    {15'b0, fetch_valid_o}, {15'b0, (m_mode == 1) && !s});
    check("pc",       fetch_pc_o, m_pc);
    check("flush",    {15'b0, flush_o}, {15'b0, m_flush});
    check("misalign", {15'b0, misalign_o}, {15'b0, m_mis});
    check("mis_addr", misalign_addr_o, m_addr);
    if (r) begin
      model_reset();
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      m_flush = 1'b0;
      if (j || jr || b) begin
        if (j)       tgt = ex + imm;
        else if (jr) tgt = alu & 16'hFFFE;
        else         tgt = ex + imm;
        m_flush = 1'b1;
        if ((tgt % INST_BYTES) != 0) begin
          m_mode = 2; m_mis = 1'b1; m_addr = tgt;
        end else begin
          m_pc = tgt;
        end
      end else if (!s && rdy) begin
        m_pc = m_pc + 16'(INST_BYTES);
      end
    end else begin
      m_flush = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        r, s, rdy, j, jr, b;
    logic [15:0] ex, imm, alu;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    cycle(1, 0, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0);

    // Boot cycle then sequential fetch 0, 4, 8, c
    cycle(0, 0, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0);
    cycle(0, 0, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0);
    check("seq_pc4", fetch_pc_o, 16'h0004);
    cycle(0, 0, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0);
    check("seq_pc8", fetch_pc_o, 16'h0008);
    cycle(0, 0, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0);
    cycle(0, 0, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0);
    check("seq_pc10", fetch_pc_o, 16'h0010);

    // Back-pressure holds the PC
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
      check("hold_pc", fetch_pc_o, 16'h0010);
    end
    cycle(0, 0, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0);
    check("release_pc", fetch_pc_o, 16'h0014);

    // jal with simultaneous fire: target wins, wraps in the adder
    cycle(0, 0, 1, 1, 0, 0, 16'h0020, 16'hFFF0, 16'h0);
    check("jal_pc", fetch_pc_o, 16'h0010);
    check("jal_flush", {15'b0, flush_o}, 16'h0001);
    cycle(0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0);

    // jalr beats branch, applied under stall
    cycle(0, 1, 1, 0, 1, 1, 16'h0300, 16'h0008, 16'h0041);
    check("jalr_pc", fetch_pc_o, 16'h0040);
    cycle(0, 1, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0);

    // Wrap of sequential increment
    cycle(0, 0, 0, 0, 1, 0, 16'h0, 16'h0, 16'hFFFC);
    cycle(0, 0, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0);
    check("wrap_pc", fetch_pc_o, 16'h0000);

    // Misaligned branch halts until reset; redirects ignored meanwhile
    cycle(0, 0, 1, 0, 0, 1, 16'h0100, 16'h0006, 16'h0);
    check("fault_mis", {15'b0, misalign_o}, 16'h0001);
    check("fault_addr", misalign_addr_o, 16'h0106);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 1, 0, 0, 16'h0040, 16'h0010, 16'h0);
    cycle(1, 0, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0);
    cycle(0, 0, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0);

    // Random traffic including occasional resets and misaligned targets
    for (int n = 0; n < 1500; n++) begin
      r   = ($urandom_range(0, 59) == 0);
      s   = ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      j   = ($urandom_range(0, 11) == 0);
      jr  = ($urandom_range(0, 11) == 0);
      b   = ($urandom_range(0, 11) == 0);
      ex  = 16'($urandom) & 16'hFFFC;
      imm = ($urandom_range(0, 15) == 0) ? 16'($urandom) : (16'($urandom) & 16'hFFFC);
      alu = ($urandom_range(0, 15) == 0) ? 16'($urandom) : (16'($urandom) & 16'hFFFD);
      cycle(r, s, rdy, j, jr, b, ex, imm, alu);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
